execute_hi_lo_unit: RTL and testbench

- Execute-stage consumer of the decode/execute pipeline register outputs; owns the architectural HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU iteratively over 32 cycles, serves MFHI/MFLO reads, and performs MTHI/MTLO writes.
- Drives a stall request to the hazard unit while an iterative operation is in flight.

---
 rtl/hi_lo_pkg.sv | 37 +++
 rtl/hi_lo_iterative_core.sv | 142 ++++++++++++++
 rtl/execute_hi_lo_unit.sv | 82 ++++++++
 tb/tb_execute_hi_lo_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hi_lo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hi_lo_pkg
// Brief    : Shared funct codes, FSM state type and decode helpers for the
//            execute-stage HI/LO unit.
// Revision : 1.0  initial release
// ============================================================================
package hi_lo_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } hi_lo_state_t;

  // True for the move group (0x10-0x13) and the mult/div group (0x18-0x1B).
  function automatic logic is_hi_lo_funct(input logic [5:0] funct);
    return (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
  endfunction

  // True only for MULT, MULTU, DIV, DIVU.
  function automatic logic is_mul_div_funct(input logic [5:0] funct);
    return (funct[5:2] == 4'b0110);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hi_lo_iterative_core.sv
`default_nettype none
// ============================================================================
// Module   : hi_lo_iterative_core
// Brief    : One-bit-per-cycle shift-add multiplier and restoring divider
//            with iteration counter, sign fix-up and divide-by-zero handling.
// Revision : 1.0  initial release
// ============================================================================
module hi_lo_iterative_core
  import hi_lo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start_i,
  input  logic                  div_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_result_o,
  output logic [DATA_WIDTH-1:0] lo_result_o
);

  hi_lo_state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0]       count_q;
  logic [DATA_WIDTH-1:0]        acc_q;     // product high half / partial remainder
  logic [DATA_WIDTH-1:0]        low_q;     // multiplier bits / dividend-then-quotient
  logic [DATA_WIDTH-1:0]        opb_q;     // multiplicand / divisor magnitude
  logic [DATA_WIDTH-1:0]        raw_a_q;   // unmodified dividend for divide by zero
  logic                         neg_lo_q;  // operand signs differ
  logic                         neg_hi_q;  // dividend was negative
  logic                         is_div_q;
  logic                         dbz_q;

  logic                         w_a_neg, w_b_neg;
  logic [DATA_WIDTH-1:0]        w_a_mag, w_b_mag;
  logic [DATA_WIDTH:0]          w_mul_sum;
  logic [DATA_WIDTH:0]          w_div_shift;
  logic [DATA_WIDTH:0]          w_div_diff;
  logic                         w_div_ge;
  logic                         w_last_iter;
  logic [2*DATA_WIDTH-1:0]      w_product;

  assign w_a_neg = signed_i & op_a_i[DATA_WIDTH-1];
  assign w_b_neg = signed_i & op_b_i[DATA_WIDTH-1];
  // Negating the most negative value wraps to itself, which is the correct
  // unsigned magnitude.
  assign w_a_mag = w_a_neg ? (~op_a_i + 1'b1) : op_a_i;
  assign w_b_mag = w_b_neg ? (~op_b_i + 1'b1) : op_b_i;

  assign w_mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
  assign w_div_shift = {acc_q, low_q[DATA_WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, opb_q};
  assign w_div_ge    = (w_div_shift >= {1'b0, opb_q});
  assign w_last_iter = (count_q == COUNT_WIDTH'(1));
  assign w_product   = {acc_q, low_q};

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: count down DATA_WIDTH iterations, then one fix-up cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = div_i ? DIV : MUL;
      MUL:     if (w_last_iter) state_d = DONE;
      DIV:     if (w_last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one multiplier/quotient bit per cycle.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count_q  <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      opb_q    <= '0;
      raw_a_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            count_q  <= COUNT_WIDTH'(DATA_WIDTH);
            acc_q    <= '0;
            low_q    <= w_a_mag;
            opb_q    <= w_b_mag;
            raw_a_q  <= op_a_i;
            neg_lo_q <= w_a_neg ^ w_b_neg;
            neg_hi_q <= w_a_neg;
            is_div_q <= div_i;
            dbz_q    <= div_i & (op_b_i == '0);
          end
        end
        MUL: begin
          {acc_q, low_q} <= {w_mul_sum, low_q[DATA_WIDTH-1:1]};
          count_q        <= count_q - COUNT_WIDTH'(1);
        end
        DIV: begin
          acc_q   <= w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
          low_q   <= {low_q[DATA_WIDTH-2:0], w_div_ge};
          count_q <= count_q - COUNT_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Final sign fix-up; divide by zero reports all-ones quotient and raw dividend.
  always_comb begin
    hi_result_o = w_product[2*DATA_WIDTH-1:DATA_WIDTH];
    lo_result_o = w_product[DATA_WIDTH-1:0];
    if (is_div_q) begin
      if (dbz_q) begin
        hi_result_o = raw_a_q;
        lo_result_o = '1;
      end else begin
        hi_result_o = neg_hi_q ? (~acc_q + 1'b1) : acc_q;
        lo_result_o = neg_lo_q ? (~low_q + 1'b1) : low_q;
      end
    end else if (neg_lo_q) begin
      {hi_result_o, lo_result_o} = ~w_product + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_hi_lo_unit.sv
`default_nettype none
// ============================================================================
// Module   : execute_hi_lo_unit
// Brief    : Execute-stage owner of the HI/LO registers: decodes HI/LO functs,
//            launches iterative mult/div, serves MFHI/MFLO and raises a stall
//            while an iterative operation is in flight.
// Revision : 1.0  initial release
// ============================================================================
module execute_hi_lo_unit
  import hi_lo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  op_valid,
  input  logic [5:0]            ALU_function_execute,
  input  logic [DATA_WIDTH-1:0] source_A_execute,
  input  logic [DATA_WIDTH-1:0] source_B_execute,
  output logic [DATA_WIDTH-1:0] hi_lo_read_data_execute,
  output logic [DATA_WIDTH-1:0] hi_execute,
  output logic [DATA_WIDTH-1:0] lo_execute,
  output logic                  busy_execute,
  output logic                  stall_hi_lo
);

  logic [DATA_WIDTH-1:0] hi_q, lo_q;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_core_done;
  logic [DATA_WIDTH-1:0] w_core_hi, w_core_lo;

  // Instructions are only taken while the iterative core is idle.
  assign w_accept = op_valid & ~busy_execute;
  assign w_start  = w_accept & is_mul_div_funct(ALU_function_execute);

  hi_lo_iterative_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_core (
    .clk         (clk),
    .clear_n     (clear_n),
    .start_i     (w_start),
    .div_i       (ALU_function_execute[1]),
    .signed_i    (~ALU_function_execute[0]),
    .op_a_i      (source_A_execute),
    .op_b_i      (source_B_execute),
    .busy_o      (busy_execute),
    .done_o      (w_core_done),
    .hi_result_o (w_core_hi),
    .lo_result_o (w_core_lo)
  );

  // HI/LO architectural state: iterative results or direct moves from Rs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (w_core_done) begin
      hi_q <= w_core_hi;
      lo_q <= w_core_lo;
    end else if (w_accept && (ALU_function_execute == FUNCT_MTHI)) begin
      hi_q <= source_A_execute;
    end else if (w_accept && (ALU_function_execute == FUNCT_MTLO)) begin
      lo_q <= source_A_execute;
    end
  end

  // Read mux for MFHI/MFLO; zero for any other funct.
  always_comb begin
    hi_lo_read_data_execute = '0;
    if (ALU_function_execute == FUNCT_MFHI)      hi_lo_read_data_execute = hi_q;
    else if (ALU_function_execute == FUNCT_MFLO) hi_lo_read_data_execute = lo_q;
  end

  assign stall_hi_lo = op_valid & is_hi_lo_funct(ALU_function_execute) & busy_execute;
  assign hi_execute  = hi_q;
  assign lo_execute  = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_hi_lo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_hi_lo_unit
// Brief    : Directed self-checking bench for execute_hi_lo_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_execute_hi_lo_unit;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [5:0]  funct = 6'h20;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] rd_data, hi_o, lo_o;
  logic        busy, stall;

  int n_checks = 0;
  int n_pass   = 0;

  execute_hi_lo_unit #(.DATA_WIDTH(32)) dut (
    .clk                     (clk),
    .clear_n                 (clear_n),
    .op_valid                (op_valid),
    .ALU_function_execute    (funct),
    .source_A_execute        (src_a),
    .source_B_execute        (src_b),
    .hi_lo_read_data_execute (rd_data),
    .hi_execute              (hi_o),
    .lo_execute              (lo_o),
    .busy_execute            (busy),
    .stall_hi_lo             (stall)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one iterative op, count busy cycles, then check HI/LO.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge clk);
    op_valid = 1'b1; funct = f; src_a = x; src_b = y;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_value({tag, " busy_cycles"}, 32'(cyc), 32'd33);
    check_value({tag, " hi"}, hi_o, exp_hi);
    check_value({tag, " lo"}, lo_o, exp_lo);
  endtask

  initial begin
    int cyc;
    int stall_cnt;

    // Reset state
    #1;
    check_value("reset hi", hi_o, 32'h0);
    check_value("reset lo", lo_o, 32'h0);
    check_value("reset busy", 32'(busy), 32'h0);
    check_value("reset stall", 32'(stall), 32'h0);
    check_value("reset rd", rd_data, 32'h0);
    @(negedge clk); clear_n = 1'b1;

    // MTHI / MTLO then MFHI / MFLO
    @(negedge clk);
    op_valid = 1'b1; funct = 6'h11; src_a = 32'h12345678;
    @(posedge clk); #1;
    check_value("mthi hi", hi_o, 32'h12345678);
    funct = 6'h13; src_a = 32'h9ABCDEF0;
    @(posedge clk); #1;
    check_value("mtlo lo", lo_o, 32'h9ABCDEF0);
    funct = 6'h10; #1;
    check_value("mfhi rd", rd_data, 32'h12345678);
    check_value("mfhi stall", 32'(stall), 32'h0);
    funct = 6'h12; #1;
    check_value("mflo rd", rd_data, 32'h9ABCDEF0);
    check_value("mflo stall", 32'(stall), 32'h0);
    op_valid = 1'b0; funct = 6'h20;

    run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  6'h18, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",   6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",      6'h1B, 32'd100,      32'd7,        32'd2,        32'd14);

    // MFLO presented during a DIV stalls until the result is written
    @(negedge clk);
    op_valid = 1'b1; funct = 6'h1A; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
    repeat (4) @(posedge clk);
    #1;
    op_valid = 1'b1; funct = 6'h12;
    #1;
    check_value("stall mflo first", 32'(stall), 32'h1);
    funct = 6'h20;
    #1;
    check_value("stall add", 32'(stall), 32'h0);
    check_value("stall add busy", 32'(busy), 32'h1);
    funct = 6'h12;
    #1;
    cyc = 0; stall_cnt = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (stall === 1'b1) stall_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check_value("stall cycles", 32'(stall_cnt), 32'd29);
    check_value("stall released", 32'(stall), 32'h0);
    check_value("stall mflo rd", rd_data, 32'd14);
    check_value("stall div hi", hi_o, 32'd2);
    @(negedge clk); op_valid = 1'b0; funct = 6'h20;

    run_op("div_by_zero",     6'h1A, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_op("div_neg_by_zero", 6'h1A, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_min_m1",      6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
    run_op("mult_min_min",    6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

    // Asynchronous abort at cycle 10 of a MULT
    @(negedge clk);
    op_valid = 1'b1; funct = 6'h18; src_a = 32'hFFFFFFF9; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
    repeat (9) @(posedge clk);
    #3;
    clear_n = 1'b0;
    #1;
    check_value("abort busy", 32'(busy), 32'h0);
    check_value("abort hi", hi_o, 32'h0);
    check_value("abort lo", lo_o, 32'h0);
    @(negedge clk); clear_n = 1'b1;

    run_op("multu_after_abort", 6'h19, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
